// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
// The optional FETCH_COUNTER_EN feature lives in instr_fetch.sv.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  localparam int          FETCH_ADDR_W      = 6;
  localparam int          FETCH_DATA_W      = 8;
  localparam logic [7:0]  FETCH_HALT_OPCODE = 8'hFF;

endpackage

// File: rtl/instr_fetch.sv
// Fetch stage in front of a 1-cycle registered ROM: owns the PC and presents instr + PC tag
// over valid/ready. Define FETCH_COUNTER_EN to add the saturating instr_count output.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int                ADDR_W      = FETCH_ADDR_W,
  parameter int                DATA_W      = FETCH_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter logic [DATA_W-1:0] HALT_OPCODE = DATA_W'(FETCH_HALT_OPCODE)
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              start,
  output logic              halted,
  output logic [1:0]        fsm_state
`ifdef FETCH_COUNTER_EN
  ,
  output logic [15:0]       instr_count
`endif
);

  // Handshake: a word transfers on any posedge where instr_valid && instr_ready (fire);
  // instr/instr_pc hold while valid and not ready; instr_valid never depends on instr_ready.

  fetch_state_t      state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_inc;
  logic              valid_q;
  logic              fire;

  assign pc_inc      = pc_q + ADDR_W'(1);
  assign instr_valid = valid_q && !redirect_valid && (state_q == RUN);
  assign fire        = instr_valid && instr_ready;
  assign instr       = rom_data;
  assign instr_pc    = pc_q;
  assign halted      = (state_q == HALT);
  assign fsm_state   = state_q;

  // rom_addr is always the PC whose word must be on rom_data next cycle.
  always_comb begin
    rom_addr = pc_q;
    case (state_q)
      BOOT:    rom_addr = RESET_PC;
      RUN: begin
        if (redirect_valid)  rom_addr = redirect_pc;
        else if (fire)       rom_addr = pc_inc;
        else                 rom_addr = pc_q;
      end
      HALT:    rom_addr = redirect_valid ? redirect_pc : pc_q;
      default: rom_addr = pc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        BOOT: begin
          state_q <= RUN;
          pc_q    <= RESET_PC;
          valid_q <= 1'b1;
        end
        RUN: begin
          if (fire && (rom_data == HALT_OPCODE)) begin
            state_q <= HALT;
            valid_q <= 1'b0;
            pc_q    <= pc_inc;
          end else begin
            pc_q    <= rom_addr;
            valid_q <= 1'b1;
          end
        end
        HALT: begin
          if (redirect_valid) pc_q <= redirect_pc;
          if (start) begin
            state_q <= RUN;
            valid_q <= 1'b1;
          end
        end
        default: begin
          state_q <= BOOT;
          pc_q    <= RESET_PC;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_COUNTER_EN
  always_ff @(posedge clk) begin
    if (rst)                               instr_count <= '0;
    else if (fire && instr_count != 16'hFFFF) instr_count <= instr_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: ROM model, transaction-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_instr_fetch;

  logic       clk;
  logic       rst;
  logic [5:0] rom_addr;
  logic [7:0] rom_data;
  logic [7:0] instr;
  logic [5:0] instr_pc;
  logic       instr_valid;
  logic       instr_ready;
  logic       redirect_valid;
  logic [5:0] redirect_pc;
  logic       start;
  logic       halted;
  logic [1:0] dbg_state;
`ifdef FETCH_COUNTER_EN
  logic [15:0] instr_count;
`endif

  logic [7:0] mem [64];
  int total = 0;
  int bad   = 0;

  instr_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .start          (start),
    .halted         (halted),
    .fsm_state      (dbg_state)
`ifdef FETCH_COUNTER_EN
    ,
    .instr_count    (instr_count)
`endif
  );

  // clock / ROM
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= mem[rom_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance until the DUT presents pc p as valid (bounded).
  task automatic wait_pc(input logic [5:0] p);
    bit found;
    found = 1'b0;
    for (int n = 0; n < 150 && !found; n++) begin
      step();
      if (instr_valid && instr_pc == p) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL wait_pc: pc %0d never presented (timeout)", p);
    end
  endtask

  // Reference model: the next PC to present, whether a bubble is pending, whether halted.
  bit         m_init   = 1'b0;
  bit         m_bubble = 1'b1;
  bit         m_halted = 1'b0;
  logic [5:0] m_pc     = '0;
  int         m_count  = 0;
  bit         exp_valid;

  always @(negedge clk) begin
    if (!m_init) begin
      if (rst) begin
        m_init = 1'b1; m_pc = '0; m_bubble = 1'b1; m_halted = 1'b0; m_count = 0;
      end
    end else begin
      exp_valid = !m_halted && !m_bubble && !redirect_valid;
      chk("m_valid", instr_valid, exp_valid);
      chk("m_halted", halted, m_halted);
      if (exp_valid) begin
        chk("m_pc", instr_pc, m_pc);
        chk("m_instr", instr, mem[m_pc]);
      end
`ifdef FETCH_COUNTER_EN
      chk("m_count", instr_count, m_count);
`endif
      if (rst) begin
        m_pc = '0; m_bubble = 1'b1; m_halted = 1'b0; m_count = 0;
      end else if (m_halted) begin
        if (redirect_valid) m_pc = redirect_pc;
        if (start) begin m_halted = 1'b0; m_bubble = 1'b0; end
      end else if (m_bubble) begin
        m_bubble = 1'b0;
      end else if (redirect_valid) begin
        m_pc = redirect_pc;
      end else if (instr_ready) begin
        if (m_count < 65535) m_count++;
        if (mem[m_pc] == 8'hFF) m_halted = 1'b1;
        m_pc = m_pc + 6'd1;
      end
      if (!rst) chk("m_rom_addr", rom_addr, m_pc);
    end
  end

  // directed stimulus
  initial begin
    rst = 1'b1; instr_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; start = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 8'(i);
    step(); step();
    rst = 1'b0;

    @(negedge clk);
    chk("boot_valid", instr_valid, 0);
    chk("boot_rom_addr", rom_addr, 0);
    chk("boot_halted", halted, 0);
    chk("boot_pc", instr_pc, 0);
    step();
    @(negedge clk);
    chk("first_valid", instr_valid, 1);
    chk("first_pc", instr_pc, 0);
    chk("first_instr", instr, 8'h00);
    step();
    @(negedge clk);
    chk("second_pc", instr_pc, 1);
    chk("second_instr", instr, 8'h01);

    // stall at pc 5
    wait_pc(6'd5);
    instr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_pc", instr_pc, 5);
      chk("stall_instr", instr, 8'h05);
      chk("stall_rom_addr", rom_addr, 5);
      step();
    end
    instr_ready = 1'b1;
    @(negedge clk);
    chk("release_rom_addr", rom_addr, 6);
    step();
    @(negedge clk);
    chk("after_stall_pc", instr_pc, 6);

    // wrap 63 -> 0
    wait_pc(6'd63);
    @(negedge clk);
    chk("pc63_instr", instr, 8'h3F);
    step();
    @(negedge clk);
    chk("wrap_pc", instr_pc, 0);
    chk("wrap_instr", instr, 8'h00);

    // redirect at pc 10 to 40
    wait_pc(6'd10);
    redirect_valid = 1'b1; redirect_pc = 6'd40;
    @(negedge clk);
    chk("redir_kill", instr_valid, 0);
    chk("redir_rom_addr", rom_addr, 40);
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("redir_valid", instr_valid, 1);
    chk("redir_pc", instr_pc, 40);
    chk("redir_instr", instr, 8'h28);

    // halt on mem[7] = FF, then restart
    mem[7] = 8'hFF;
    redirect_valid = 1'b1; redirect_pc = 6'd3;
    step();
    redirect_valid = 1'b0;
    wait_pc(6'd7);
    @(negedge clk);
    chk("halt_instr", instr, 8'hFF);
    step();
    @(negedge clk);
    chk("halt_halted", halted, 1);
    chk("halt_valid", instr_valid, 0);
    step(); step();
    @(negedge clk);
    chk("halt_hold", halted, 1);
    chk("halt_rom_addr", rom_addr, 8);
    start = 1'b1;
    step();
    start = 1'b0;
    @(negedge clk);
    chk("restart_halted", halted, 0);
    chk("restart_valid", instr_valid, 1);
    chk("restart_pc", instr_pc, 8);
    chk("restart_instr", instr, 8'h08);
    mem[7] = 8'h07;

    // fresh run, reset in the middle of a stall at pc 20
    rst = 1'b1;
    step();
    rst = 1'b0;
    wait_pc(6'd20);
    instr_ready = 1'b0;
    step(); step();
    @(negedge clk);
    chk("midstall_pc", instr_pc, 20);
`ifdef FETCH_COUNTER_EN
    chk("count_before_rst", instr_count, 20);
`endif
    rst = 1'b1;
    step();
    @(negedge clk);
    chk("rst_valid", instr_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_pc", instr_pc, 0);
    chk("rst_rom_addr", rom_addr, 0);
`ifdef FETCH_COUNTER_EN
    chk("count_after_rst", instr_count, 0);
`endif
    rst = 1'b0;
    instr_ready = 1'b1;
    repeat (10) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
